// File: rtl/rr_arb8_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb8_ctrl
// Brief    : 8-way round-robin arbiter with registered one-hot + encoded grant,
//            held until the owner releases. Optional forced release after
//            HOLD_MAX grant cycles when RR_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb8_ctrl #(
    parameter int NREQ     = 8,
    parameter int IDX_W    = 3,
    parameter int HOLD_MAX = 15,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_vld;
    logic [IDX_W-1:0] r_ptr;

    logic             w_any;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_cand;
    logic             w_force;
    logic             w_release;

    // Size sanity: only the 8-requester / 3-bit index build is supported,
    // and the hold counter must be able to represent HOLD_MAX.
    if (NREQ == 8 && IDX_W == 3 && HOLD_MAX < (1 << HOLD_W)) begin : g_cfg_ok
    end else begin : g_cfg_unsupported
    end

    // Wrap-around scan starting at r_ptr; the index adder wraps naturally mod 8.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = r_ptr + IDX_W'(i);
            if (!w_any && req[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] r_hold;
    logic              r_timeout;

    // r_hold counts GRANT cycles already elapsed; release on the edge that
    // would bring it to HOLD_MAX, so the grant lasts exactly HOLD_MAX cycles.
    assign w_force = (r_hold == HOLD_W'(HOLD_MAX - 1));
    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    assign w_release = done | ~req[r_gnt_idx] | w_force;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
            r_ptr     <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            r_hold    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt     <= NREQ'(1) << w_win;
                        r_gnt_idx <= w_win;
                        r_gnt_vld <= 1'b1;
                        r_state   <= S_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                        r_hold    <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_gnt     <= '0;
                        r_gnt_idx <= '0;
                        r_gnt_vld <= 1'b0;
                        r_ptr     <= r_gnt_idx + 1'b1;
                        r_state   <= S_RELEASE;
`ifdef RR_ARB_TIMEOUT_EN
                        r_timeout <= w_force;
                    end else begin
                        r_hold    <= r_hold + 1'b1;
`endif
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb8_ctrl
// Brief    : Scoreboard bench for rr_arb8_ctrl; stimulus pushes expected grants,
//            a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb8_ctrl;

    localparam int HOLD_MAX = 15;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'h00;
    logic       done  = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    rr_arb8_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int len;
        bit to;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   ptr_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: first requester found scanning ptr, ptr+1, ... modulo 8.
    function automatic int model_win(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    // Precondition: DUT is IDLE and will arbitrate on the next posedge.
    // Holds the grant l cycles, then releases by done or by dropping the owner's request.
    task automatic issue(input logic [7:0] r, input int l, input bit drop);
        exp_t e;
        int   w;
        int   lr;
        bit   forced;
        w      = model_win(r, ptr_m);
        forced = TO_EN && (l >= HOLD_MAX);
        lr     = forced ? HOLD_MAX : l;
        e.idx  = w;
        e.len  = lr;
        e.to   = forced;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
        ptr_m  = (w + 1) % 8;
        req    = r;
        done   = 1'b0;
        repeat (lr) @(negedge clk);
        if (!(TO_EN && l > HOLD_MAX)) begin
            if (drop) req = r & ~(8'h01 << w);
            else      done = 1'b1;
        end
        @(negedge clk);
        // RELEASE bubble: anything driven here must be ignored
        done = 1'($urandom_range(0, 1));
        req  = 8'($urandom);
        @(negedge clk);
        done = 1'b0;
        req  = 8'h00;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            req  = 8'h00;
            done = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        done = 1'b0;
    endtask

    // Monitor
    bit   act_m = 1'b0;
    int   len_m = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            act_m = 1'b0;
            len_m = 0;
        end else begin
            if (gnt_vld) chk("grant_onehot", {24'h0, gnt}, {24'h0, 8'h01 << gnt_idx});
            else         chk("idle_zero", {21'h0, gnt_idx, gnt}, 32'h0);
            if (gnt_vld && !act_m) begin
                chk("timeout_in_grant", {31'h0, timeout}, 32'h0);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_grant: actual idx=%0d required no grant at t=%0t", gnt_idx, $time);
                end else begin
                    cur = sb_q.pop_front();
                    chk("grant_idx", {29'h0, gnt_idx}, cur.idx);
                    chk("grant_latency", cyc, cur.cyc);
                    act_m = 1'b1;
                    len_m = 1;
                end
            end else if (gnt_vld) begin
                chk("timeout_in_grant", {31'h0, timeout}, 32'h0);
                chk("hold_stable", {29'h0, gnt_idx}, cur.idx);
                len_m++;
            end else if (act_m) begin
                chk("grant_len", len_m, cur.len);
                chk("timeout_pulse", {31'h0, timeout}, {31'h0, cur.to});
                act_m = 1'b0;
            end else begin
                chk("timeout_quiet", {31'h0, timeout}, 32'h0);
            end
        end
    end

    initial begin
        exp_t e;
        logic [7:0] r;

        // Reset with every requester asserted
        rst_n = 1'b0;
        req   = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_gnt", {24'h0, gnt}, 32'h0);
        chk("rst_vld", {31'h0, gnt_vld}, 32'h0);
        chk("rst_idx", {29'h0, gnt_idx}, 32'h0);
        chk("rst_timeout", {31'h0, timeout}, 32'h0);
        rst_n = 1'b1;
        issue(8'h01, 2, 1'b0);

        // Rotation with all requesting, done one cycle after each grant
        for (int i = 0; i < 9; i++) issue(8'hFF, 1, 1'b0);
        issue(8'hFF, 1, 1'b0);

        // Fairness wrap: ptr=3, req=05 -> 0 then 2
        issue(8'h05, 2, 1'b0);
        issue(8'h05, 2, 1'b0);

        // Owner 4 drops its request; next scan starts at 5
        issue(8'h11, 3, 1'b1);
        issue(8'h11, 1, 1'b0);

        // Async reset in the middle of a grant to requester 6
        e.idx = model_win(8'h40, ptr_m);
        e.len = 0;
        e.to  = 1'b0;
        e.cyc = cyc + 1;
        sb_q.push_back(e);
        req = 8'h40;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vld", {31'h0, gnt_vld}, 32'h0);
        chk("async_rst_gnt", {24'h0, gnt}, 32'h0);
        chk("async_rst_idx", {29'h0, gnt_idx}, 32'h0);
        ptr_m = 0;
        req   = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(8'hFF, 2, 1'b0);

        // Long hold without done, and a hold ending exactly at HOLD_MAX with done
        issue(8'h02, 120, 1'b0);
        issue(8'h08, HOLD_MAX, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            r = 8'($urandom_range(1, 255));
            issue(r, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 4)));
        end

        gap(4);
        chk("scoreboard_empty", sb_q.size(), 32'h0);
        chk("no_open_grant", {31'h0, act_m}, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
